// File: rtl/predecode_stage_pkg.sv
// Shared widths, opcode constants and the fetch bundle layout for the pre-decode stage.
package predecode_stage_pkg;

  localparam int FPD_BUS_W     = 75;
  localparam int PREDICT_BUS_W = 33;
  localparam int PDD_BUS_W     = 108;

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  // Field order matches FpD_BUS bit positions, msb first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pc_en;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
  } fpd_bus_t;

endpackage

// File: rtl/predecode_stage_if.sv
// Fetch -> pre-decode -> decode handshake bundle; slave modport is the stage itself.
interface predecode_stage_if;
  import predecode_stage_pkg::*;

  logic                     FpD_valid;
  logic [FPD_BUS_W-1:0]     FpD_BUS;
  logic                     pD_allowin;
  logic                     flush;
  logic [PREDICT_BUS_W-1:0] predict_BUS;
  logic                     D_allowin;
  logic                     pDD_valid;
  logic [PDD_BUS_W-1:0]     pDD_BUS;

  modport slave (
    input  FpD_valid, FpD_BUS, flush, D_allowin,
    output pD_allowin, predict_BUS, pDD_valid, pDD_BUS
  );

  modport master (
    output FpD_valid, FpD_BUS, flush, D_allowin,
    input  pD_allowin, predict_BUS, pDD_valid, pDD_BUS
  );

endinterface

// File: rtl/predecode_stage_pd_branch_detect.sv
// Static branch detector on a raw instruction word (module pd_branch_detect).
// Backward-taken/forward-not-taken for conditional branches is enabled by PD_BTFN_EN.
module pd_branch_detect
  import predecode_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        is_br,
  output logic        taken,
  output logic [31:0] target
);

  logic [5:0]  op;
  logic        is_uncond;
  logic        is_cond;
  logic [31:0] off_uncond;
  logic [31:0] off_cond;

  always_comb begin
    op         = inst[31:26];
    is_uncond  = (op == OP_B) || (op == OP_BL);
    is_cond    = (op >= OP_BEQ) && (op <= OP_BGEU);
    off_uncond = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    off_cond   = {{14{inst[25]}}, inst[25:10], 2'b00};
    is_br      = is_uncond | is_cond;
`ifdef PD_BTFN_EN
    taken      = is_uncond | (is_cond & inst[25]);
`else
    taken      = is_uncond;
`endif
    target     = taken ? (pc + (is_uncond ? off_uncond : off_cond)) : (pc + 32'd4);
  end

endmodule

// File: rtl/predecode_stage.sv
// Pre-decode stage: registers the fetch bundle, predicts static branches, drops wrong-path words.
// Optional macro PD_BTFN_EN turns on backward-taken prediction for conditional branches.
module predecode_stage
  import predecode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  predecode_stage_if.slave  pd_if
);

  fpd_bus_t    in_bus;
  logic        det_is_br;
  logic        det_taken;
  logic [31:0] det_target;

  logic        pD_valid_q,     pD_valid_d;
  fpd_bus_t    bundle_q,       bundle_d;
  logic        pred_taken_q,   pred_taken_d;
  logic [31:0] pred_target_q,  pred_target_d;
  logic        pred_sent_q,    pred_sent_d;
  logic        drop_pending_q, drop_pending_d;
  logic [31:0] drop_target_q,  drop_target_d;

  logic        pd_allowin;
  logic        pred_fire;
  logic        accept;
  logic        drop;

  assign in_bus = pd_if.FpD_BUS;

  pd_branch_detect u_detect (
    .pc     (in_bus.pc),
    .inst   (in_bus.inst),
    .is_br  (det_is_br),
    .taken  (det_taken),
    .target (det_target)
  );

  assign pd_allowin = !pD_valid_q | pd_if.D_allowin;
  assign pred_fire  = pD_valid_q & pred_taken_q & !pred_sent_q;
  assign accept     = pd_if.FpD_valid & pd_allowin & !pd_if.flush;
  assign drop       = drop_pending_q & (in_bus.pc != drop_target_q);

  assign pd_if.pD_allowin  = pd_allowin;
  assign pd_if.pDD_valid   = pD_valid_q & !pd_if.flush;
  assign pd_if.pDD_BUS     = {bundle_q, pred_taken_q, pred_target_q};
  assign pd_if.predict_BUS = (pred_fire & !pd_if.flush) ? {1'b1, pred_target_q} : '0;

  always_comb begin
    pD_valid_d     = pD_valid_q;
    bundle_d       = bundle_q;
    pred_taken_d   = pred_taken_q;
    pred_target_d  = pred_target_q;
    pred_sent_d    = pred_sent_q;
    drop_pending_d = drop_pending_q;
    drop_target_d  = drop_target_q;
    if (pd_if.flush) begin
      pD_valid_d     = 1'b0;
      pred_sent_d    = 1'b0;
      drop_pending_d = 1'b0;
    end else begin
      if (pd_if.D_allowin) pD_valid_d = 1'b0;
      if (accept) begin
        pD_valid_d    = !drop;
        bundle_d      = in_bus;
        pred_taken_d  = det_is_br & det_taken & !in_bus.ex;
        pred_target_d = in_bus.ex ? (in_bus.pc + 32'd4) : det_target;
        pred_sent_d   = 1'b0;
        if (drop_pending_q && !drop) drop_pending_d = 1'b0;
      end
      // A fresh prediction re-arms the drop window even if this edge just matched the old target.
      if (pred_fire) begin
        drop_pending_d = 1'b1;
        drop_target_d  = pred_target_q;
        if (!accept) pred_sent_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pD_valid_q     <= 1'b0;
      bundle_q       <= '0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= '0;
      pred_sent_q    <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_target_q  <= '0;
    end else begin
      pD_valid_q     <= pD_valid_d;
      bundle_q       <= bundle_d;
      pred_taken_q   <= pred_taken_d;
      pred_target_q  <= pred_target_d;
      pred_sent_q    <= pred_sent_d;
      drop_pending_q <= drop_pending_d;
      drop_target_q  <= drop_target_d;
    end
  end

endmodule

// File: tb/tb_predecode_stage.sv
// Directed bench for predecode_stage: prediction, wrong-path drop, stall, flush, exception, streaming.
module tb_predecode_stage;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  predecode_stage_if pif ();

  predecode_stage dut (
    .clk   (clk),
    .rstn  (rstn),
    .pd_if (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] INST_B    = 32'h5000_1000;
  localparam logic [31:0] INST_NOP  = 32'h0340_0000;
  localparam logic [31:0] INST_BEQB = 32'h5BFF_F000;
  localparam logic [31:0] INST_BEQF = 32'h5800_1000;
  localparam logic [31:0] INST_BLM4 = 32'h57FF_FFFF;

  function automatic logic [74:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic ex, input logic [7:0] ecode,
                                      input logic esub, input logic pc_en);
    return {pc, inst, pc_en, ex, ecode, esub};
  endfunction

  task automatic put(input logic v, input logic [74:0] b);
    pif.FpD_valid = v;
    pif.FpD_BUS   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stage();
    put(1'b0, '0);
    pif.flush = 1'b1;
    tick();
    pif.flush     = 1'b0;
    pif.D_allowin = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    put(1'b0, '0);
    pif.flush     = 1'b0;
    pif.D_allowin = 1'b1;
    #3;
    n_tests++; if (pif.pDD_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pdd_valid got %b exp 0", pif.pDD_valid); end
    n_tests++; if (pif.predict_BUS !== 33'h0) begin n_fail++; $display("FAIL reset_predict got %h exp 0", pif.predict_BUS); end
    n_tests++; if (pif.pD_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %b exp 1", pif.pD_allowin); end
    n_tests++; if (pif.pDD_BUS !== 108'h0) begin n_fail++; $display("FAIL reset_pdd_bus got %h exp 0", pif.pDD_BUS); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_b_and_drop();
    logic [74:0] b;
    b = mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1);
    put(1'b1, b);
    tick();
    n_tests++; if (pif.predict_BUS !== {1'b1, 32'h1c00_0010}) begin n_fail++; $display("FAIL b_predict got %h exp 11c000010", pif.predict_BUS); end
    n_tests++; if (pif.pDD_valid !== 1'b1) begin n_fail++; $display("FAIL b_pdd_valid got %b exp 1", pif.pDD_valid); end
    n_tests++; if (pif.pDD_BUS !== {b, 1'b1, 32'h1c00_0010}) begin n_fail++; $display("FAIL b_pdd_bus got %h exp %h", pif.pDD_BUS, {b, 1'b1, 32'h1c00_0010}); end
    put(1'b0, '0);
    tick();
    n_tests++; if (pif.predict_BUS !== 33'h0) begin n_fail++; $display("FAIL b_predict_once got %h exp 0", pif.predict_BUS); end
    put(1'b1, mk(32'h1c00_0004, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b0) begin n_fail++; $display("FAIL drop_wrong_path got %b exp 0", pif.pDD_valid); end
    n_tests++; if (pif.pD_allowin !== 1'b1) begin n_fail++; $display("FAIL drop_allowin got %b exp 1", pif.pD_allowin); end
    put(1'b1, mk(32'h1c00_0010, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1) begin n_fail++; $display("FAIL drop_target_valid got %b exp 1", pif.pDD_valid); end
    n_tests++; if (pif.pDD_BUS[107:76] !== 32'h1c00_0010) begin n_fail++; $display("FAIL drop_target_pc got %h exp 1c000010", pif.pDD_BUS[107:76]); end
    n_tests++; if (pif.pDD_BUS[32:0] !== {1'b0, 32'h1c00_0014}) begin n_fail++; $display("FAIL nop_pred got %h exp 01c000014", pif.pDD_BUS[32:0]); end
    put(1'b1, mk(32'h1c00_0014, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1 || pif.pDD_BUS[107:76] !== 32'h1c00_0014) begin n_fail++; $display("FAIL drop_cleared got v=%b pc=%h exp v=1 pc=1c000014", pif.pDD_valid, pif.pDD_BUS[107:76]); end
    clear_stage();
  endtask

  task automatic test_cond_branch();
    logic [32:0] exp_pred;
    logic [32:0] exp_bus_pred;
`ifdef PD_BTFN_EN
    exp_pred     = {1'b1, 32'h1c00_0010};
    exp_bus_pred = {1'b1, 32'h1c00_0010};
`else
    exp_pred     = 33'h0;
    exp_bus_pred = {1'b0, 32'h1c00_0024};
`endif
    put(1'b1, mk(32'h1c00_0020, INST_BEQB, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.predict_BUS !== exp_pred) begin n_fail++; $display("FAIL beq_back_predict got %h exp %h", pif.predict_BUS, exp_pred); end
    n_tests++; if (pif.pDD_BUS[32:0] !== exp_bus_pred) begin n_fail++; $display("FAIL beq_back_pred_fields got %h exp %h", pif.pDD_BUS[32:0], exp_bus_pred); end
    clear_stage();
    put(1'b1, mk(32'h1c00_0030, INST_BEQF, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.predict_BUS !== 33'h0) begin n_fail++; $display("FAIL beq_fwd_predict got %h exp 0", pif.predict_BUS); end
    n_tests++; if (pif.pDD_BUS[32:0] !== {1'b0, 32'h1c00_0034}) begin n_fail++; $display("FAIL beq_fwd_pred_fields got %h exp 01c000034", pif.pDD_BUS[32:0]); end
    clear_stage();
    put(1'b1, mk(32'h1c00_1000, INST_BLM4, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.predict_BUS !== {1'b1, 32'h1c00_0ffc}) begin n_fail++; $display("FAIL bl_neg_predict got %h exp 11c000ffc", pif.predict_BUS); end
    clear_stage();
  endtask

  task automatic test_stall();
    logic [107:0] held;
    int pulses;
    pif.D_allowin = 1'b0;
    put(1'b1, mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    held   = {mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1, 32'h1c00_0010};
    pulses = 0;
    put(1'b1, mk(32'h1c00_0100, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      if (pif.predict_BUS[32] === 1'b1) pulses++;
      n_tests++; if (pif.pD_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_allowin cyc%0d got %b exp 0", i, pif.pD_allowin); end
      n_tests++; if (pif.pDD_BUS !== held || pif.pDD_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc%0d got v=%b %h exp v=1 %h", i, pif.pDD_valid, pif.pDD_BUS, held); end
      if (i < 4) tick();
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL stall_predict_pulses got %0d exp 1", pulses); end
    pif.D_allowin = 1'b1;
    put(1'b1, mk(32'h1c00_0010, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1 || pif.pDD_BUS[107:76] !== 32'h1c00_0010) begin n_fail++; $display("FAIL stall_release got v=%b pc=%h exp v=1 pc=1c000010", pif.pDD_valid, pif.pDD_BUS[107:76]); end
    clear_stage();
  endtask

  task automatic test_flush();
    put(1'b1, mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    pif.flush = 1'b1;
    put(1'b0, '0);
    #1;
    n_tests++; if (pif.predict_BUS !== 33'h0) begin n_fail++; $display("FAIL flush_mask_predict got %h exp 0", pif.predict_BUS); end
    n_tests++; if (pif.pDD_valid !== 1'b0) begin n_fail++; $display("FAIL flush_mask_valid got %b exp 0", pif.pDD_valid); end
    tick();
    pif.flush = 1'b0;
    put(1'b1, mk(32'h1c00_0300, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1) begin n_fail++; $display("FAIL flush_no_drop_armed got %b exp 1", pif.pDD_valid); end
    clear_stage();
    put(1'b1, mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    put(1'b0, '0);
    tick();
    pif.flush = 1'b1;
    put(1'b1, mk(32'h1c00_0200, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    pif.flush = 1'b0;
    put(1'b0, '0);
    #1;
    n_tests++; if (pif.pDD_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill got %b exp 0", pif.pDD_valid); end
    put(1'b1, mk(32'h1c00_0300, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1 || pif.pDD_BUS[107:76] !== 32'h1c00_0300) begin n_fail++; $display("FAIL flush_clears_drop got v=%b pc=%h exp v=1 pc=1c000300", pif.pDD_valid, pif.pDD_BUS[107:76]); end
    clear_stage();
  endtask

  task automatic test_exception();
    logic [74:0] b;
    b = mk(32'h1c00_0400, INST_B, 1'b1, 8'h3f, 1'b1, 1'b1);
    put(1'b1, b);
    tick();
    n_tests++; if (pif.predict_BUS !== 33'h0) begin n_fail++; $display("FAIL ex_predict got %h exp 0", pif.predict_BUS); end
    n_tests++; if (pif.pDD_BUS !== {b, 1'b0, 32'h1c00_0404}) begin n_fail++; $display("FAIL ex_bus got %h exp %h", pif.pDD_BUS, {b, 1'b0, 32'h1c00_0404}); end
    n_tests++; if (pif.pDD_BUS[41:34] !== 8'h3f) begin n_fail++; $display("FAIL ex_ecode got %h exp 3f", pif.pDD_BUS[41:34]); end
    clear_stage();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h1c00_0500; pcs[1] = 32'h1c00_0504; pcs[2] = 32'h1c00_0508;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, mk(pcs[i], INST_NOP, 1'b0, 8'h00, 1'b0, i[0]));
      tick();
      n_tests++; if (pif.pDD_valid !== 1'b1 || pif.pDD_BUS[107:76] !== pcs[i] || pif.pDD_BUS[43] !== i[0]) begin
        n_fail++; $display("FAIL b2b_%0d got v=%b pc=%h pc_en=%b exp v=1 pc=%h pc_en=%b", i, pif.pDD_valid, pif.pDD_BUS[107:76], pif.pDD_BUS[43], pcs[i], i[0]);
      end
    end
    put(1'b0, '0);
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", pif.pDD_valid); end
  endtask

  task automatic test_reset_mid_stall();
    pif.D_allowin = 1'b0;
    put(1'b1, mk(32'h1c00_0000, INST_B, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if (pif.pDD_valid !== 1'b0 || pif.pD_allowin !== 1'b1 || pif.pDD_BUS !== 108'h0) begin
      n_fail++; $display("FAIL async_reset got v=%b allowin=%b bus=%h exp v=0 allowin=1 bus=0", pif.pDD_valid, pif.pD_allowin, pif.pDD_BUS);
    end
    put(1'b0, '0);
    pif.D_allowin = 1'b1;
    tick();
    rstn = 1'b1;
    put(1'b1, mk(32'h1c00_0700, INST_NOP, 1'b0, 8'h00, 1'b0, 1'b1));
    tick();
    n_tests++; if (pif.pDD_valid !== 1'b1 || pif.pDD_BUS[107:76] !== 32'h1c00_0700) begin
      n_fail++; $display("FAIL reset_clears_drop got v=%b pc=%h exp v=1 pc=1c000700", pif.pDD_valid, pif.pDD_BUS[107:76]);
    end
    put(1'b0, '0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_b_and_drop();
    test_cond_branch();
    test_stall();
    test_flush();
    test_exception();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
